// File: rtl/input_stream_pkg.sv
// Shared defaults and helpers for the multi-channel input stream block.
// Pointer/length values are ADDR_W+1 bits so a full array length is representable.
package input_stream_pkg;

  localparam int DATA_W_DEF   = 12;
  localparam int ADDR_W_DEF   = 13;
  localparam int CHANNELS_DEF = 2;

  typedef logic [ADDR_W_DEF:0] ptr_t;

  function automatic int chan_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/input_stream_chan.sv
// One input channel: word array, read pointer, length, empty/underflow flags.
// Latency: registered read at the next pointer, so data_out tracks ptr with no bubble.
module input_stream_chan
  import input_stream_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_adv,
  input  logic              i_rewind,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_len_wr,
  input  logic [ADDR_W:0]   i_len_data,
  output logic [DATA_W-1:0] o_data,
  output logic              o_empty,
  output logic              o_underflow
);

  localparam logic [ADDR_W:0] LEN_MAX = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W+1)'(1);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];

  logic [ADDR_W:0]   r_ptr;
  logic [ADDR_W:0]   r_len;
  logic [DATA_W-1:0] r_data;
  logic              r_empty;
  logic              r_underflow;

  logic [ADDR_W:0]   w_ptr_nxt;
  logic              w_underflow_nxt;
  logic              w_empty_nxt;
  logic [ADDR_W:0]   w_len_clamped;

  always_comb begin
    w_ptr_nxt       = r_ptr;
    w_underflow_nxt = r_underflow;
    if (i_rewind) begin
      w_ptr_nxt       = '0;
      w_underflow_nxt = 1'b0;
    end else if (i_adv) begin
      if (r_empty) begin
        w_underflow_nxt = 1'b1;
      end else begin
        w_ptr_nxt = r_ptr + PTR_ONE;
      end
    end
  end

  // Emptiness uses the length in force before this edge; a new length lands one edge later.
  assign w_empty_nxt   = (w_ptr_nxt >= r_len);
  assign w_len_clamped = (i_len_data > LEN_MAX) ? LEN_MAX : i_len_data;

  always_ff @(posedge clk) begin
    if (rst && i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ptr       <= '0;
      r_len       <= '0;
      r_data      <= '0;
      r_empty     <= 1'b1;
      r_underflow <= 1'b0;
    end else begin
      r_ptr       <= w_ptr_nxt;
      r_empty     <= w_empty_nxt;
      r_underflow <= w_underflow_nxt;
      r_data      <= w_empty_nxt ? '0 : r_mem[w_ptr_nxt[ADDR_W-1:0]];
      if (i_len_wr) begin
        r_len <= w_len_clamped;
      end
    end
  end

  assign o_data      = r_data;
  assign o_empty     = r_empty;
  assign o_underflow = r_underflow;

endmodule

// File: rtl/input_stream.sv
// Multi-channel preloaded input stream for the CPU core; one channel instance per input.
// Loader writes and length updates are steered by wr_chan; out-of-range channels are ignored.
module input_stream
  import input_stream_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int CHANNELS = CHANNELS_DEF,
  localparam int CHAN_W  = chan_w(CHANNELS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [CHANNELS-1:0]        adv,
  input  logic                       rewind,
  output logic [CHANNELS*DATA_W-1:0] data_out,
  output logic [CHANNELS-1:0]        empty,
  output logic [CHANNELS-1:0]        underflow,
  input  logic                       wr_en,
  input  logic [CHAN_W-1:0]          wr_chan,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       len_wr,
  input  logic [ADDR_W:0]            len_data
);

  logic [CHANNELS-1:0] w_sel;

  always_comb begin
    w_sel = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (wr_chan == CHAN_W'(c)) begin
        w_sel[c] = 1'b1;
      end
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    input_stream_chan #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
    ) u_chan (
      .clk         (clk),
      .rst         (rst),
      .i_adv       (adv[g]),
      .i_rewind    (rewind),
      .i_wr_en     (wr_en & w_sel[g]),
      .i_wr_addr   (wr_addr),
      .i_wr_data   (wr_data),
      .i_len_wr    (len_wr & w_sel[g]),
      .i_len_data  (len_data),
      .o_data      (data_out[g*DATA_W +: DATA_W]),
      .o_empty     (empty[g]),
      .o_underflow (underflow[g])
    );
  end

endmodule
